// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle MIPS control unit with memory handshake, timeout and retire counter
//
// Sequences each instruction through IF, ID, EX, MEM and WB, handshaking with a
// variable-latency unified memory. A wait counter aborts to HALT (sticky mem_err)
// when the memory does not answer within MEM_TIMEOUT cycles (0 disables it).
// Optional build macro MULTICYCLE_CTRL_EXC_EN adds the exc output and an EXC state
// that redirects unsupported instructions to a handler vector.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   Op, Func            IR[31:26] and IR[5:0]
//   mem_rdy             memory completes the current request this cycle
//   mem_req, MemW       memory request and its write qualifier
//   IRWr, PCWr, RegW    IR load, PC update, register-file write strobes
//   NPCOp .. EXTOp      datapath decode controls
//   state               current FSM state (debug)
//   mem_err             sticky memory timeout flag
//   instret             retired-instruction count
//   exc                 exception cycle marker (MULTICYCLE_CTRL_EXC_EN only)

module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int INSTRET_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           Op,
    input  logic [5:0]           Func,
    input  logic                 mem_rdy,
    output logic                 mem_req,
    output logic                 MemW,
    output logic                 IRWr,
    output logic                 PCWr,
    output logic                 RegW,
    output logic [2:0]           NPCOp,
    output logic [1:0]           RegDst,
    output logic [1:0]           MemToReg,
    output logic                 ALUSrc1,
    output logic                 ALUSrc2,
    output logic [4:0]           ALUOp,
    output logic [1:0]           EXTOp,
    output logic [2:0]           state,
    output logic                 mem_err,
    output logic [INSTRET_W-1:0] instret
`ifdef MULTICYCLE_CTRL_EXC_EN
    ,
    output logic                 exc
`endif
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_EXC  = 3'd5,
        S_HALT = 3'd6
    } state_t;

    // The counter only has to reach MEM_TIMEOUT-1.
    localparam int                CNT_W      = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LIMIT  = CNT_W'(MEM_TIMEOUT - 1);
    localparam bit                TIMEOUT_EN = (MEM_TIMEOUT != 0);

    state_t             cur;
    state_t             nxt;
    logic [CNT_W-1:0]   wait_cnt;
    logic               waiting;
    logic               timeout;
    logic               retire;

    logic               d_legal;
    logic               d_jump;
    logic               d_jal;
    logic               d_branch;
    logic               d_lw;
    logic               d_sw;
    logic [2:0]         d_npc;
    logic [1:0]         d_rdst;
    logic [1:0]         d_m2r;
    logic               d_src1;
    logic               d_src2;
    logic [4:0]         d_alu;
    logic [1:0]         d_ext;

    assign state = cur;

    // Pure instruction decode; anything not listed is flagged illegal with all controls 0.
    always_comb begin
        d_legal  = 1'b1;
        d_jump   = 1'b0;
        d_jal    = 1'b0;
        d_branch = 1'b0;
        d_lw     = 1'b0;
        d_sw     = 1'b0;
        d_npc    = 3'b000;
        d_rdst   = 2'b00;
        d_m2r    = 2'b00;
        d_src1   = 1'b0;
        d_src2   = 1'b0;
        d_alu    = 5'd0;
        d_ext    = 2'b00;
        case (Op)
            6'h00: begin
                d_rdst = 2'b01;
                case (Func)
                    6'h21: d_alu = 5'd1;
                    6'h20: d_alu = 5'd2;
                    6'h23: d_alu = 5'd3;
                    6'h22: d_alu = 5'd4;
                    6'h2A: d_alu = 5'd9;
                    6'h00: begin d_alu = 5'd17; d_src2 = 1'b1; end
                    6'h02: begin d_alu = 5'd18; d_src2 = 1'b1; end
                    6'h03: begin d_alu = 5'd19; d_src2 = 1'b1; end
                    6'h08: begin d_alu = 5'd25; d_npc = 3'b100; d_jump = 1'b1; end
                    default: begin d_legal = 1'b0; d_rdst = 2'b00; end
                endcase
            end
            6'h23: begin d_alu = 5'd2;  d_src1 = 1'b1; d_ext = 2'b01; d_m2r = 2'b01; d_lw = 1'b1; end
            6'h2B: begin d_alu = 5'd2;  d_src1 = 1'b1; d_ext = 2'b01; d_sw = 1'b1; end
            6'h04: begin d_alu = 5'd11; d_ext = 2'b01; d_npc = 3'b001; d_branch = 1'b1; end
            6'h05: begin d_alu = 5'd12; d_npc = 3'b011; d_branch = 1'b1; end
            6'h02: begin d_alu = 5'd23; d_npc = 3'b010; d_jump = 1'b1; end
            6'h03: begin d_alu = 5'd24; d_npc = 3'b010; d_rdst = 2'b10; d_m2r = 2'b10; d_jal = 1'b1; end
            6'h0D: begin d_alu = 5'd21; d_src1 = 1'b1; end
            6'h0F: begin d_alu = 5'd22; d_src1 = 1'b1; d_ext = 2'b10; end
            6'h0A: begin d_alu = 5'd20; d_src1 = 1'b1; d_ext = 2'b01; end
            6'h08: begin d_alu = 5'd26; d_src1 = 1'b1; d_ext = 2'b01; end
            default: d_legal = 1'b0;
        endcase
    end

    // Strobes and decode outputs; everything is forced low in reset and HALT.
    always_comb begin
        mem_req  = 1'b0;
        MemW     = 1'b0;
        IRWr     = 1'b0;
        PCWr     = 1'b0;
        RegW     = 1'b0;
        NPCOp    = 3'b000;
        RegDst   = 2'b00;
        MemToReg = 2'b00;
        ALUSrc1  = 1'b0;
        ALUSrc2  = 1'b0;
        ALUOp    = 5'd0;
        EXTOp    = 2'b00;
`ifdef MULTICYCLE_CTRL_EXC_EN
        exc      = 1'b0;
`endif
        if (!rst && cur != S_HALT) begin
            NPCOp    = d_npc;
            RegDst   = d_rdst;
            MemToReg = d_m2r;
            ALUSrc1  = d_src1;
            ALUSrc2  = d_src2;
            ALUOp    = d_alu;
            EXTOp    = d_ext;
            case (cur)
                S_IF: begin
                    mem_req = 1'b1;
                    IRWr    = mem_rdy;
                end
                S_ID: begin
`ifdef MULTICYCLE_CTRL_EXC_EN
                    PCWr = d_jump;
`else
                    // Illegal instructions retire here as a nop (NPCOp already 000).
                    PCWr = d_jump | ~d_legal;
`endif
                end
                S_EX: PCWr = d_branch;
                S_MEM: begin
                    mem_req = 1'b1;
                    MemW    = d_sw;
                    PCWr    = d_sw & mem_rdy;
                end
                S_WB: begin
                    // Only register-writing instructions ever reach WB.
                    RegW = 1'b1;
                    PCWr = 1'b1;
                end
`ifdef MULTICYCLE_CTRL_EXC_EN
                S_EXC: begin
                    exc   = 1'b1;
                    PCWr  = 1'b1;
                    NPCOp = 3'b101;
                end
`endif
                default: ;
            endcase
        end
    end

    assign waiting = (cur == S_IF || cur == S_MEM) && !mem_rdy;
    assign timeout = TIMEOUT_EN && waiting && (wait_cnt == CNT_LIMIT);

`ifdef MULTICYCLE_CTRL_EXC_EN
    assign retire = PCWr & ~exc;
`else
    assign retire = PCWr;
`endif

    always_comb begin
        nxt = cur;
        case (cur)
            S_IF: begin
                if (timeout)      nxt = S_HALT;
                else if (mem_rdy) nxt = S_ID;
            end
            S_ID: begin
                if (d_jump)        nxt = S_IF;
                else if (d_jal)    nxt = S_WB;
                else if (!d_legal) begin
`ifdef MULTICYCLE_CTRL_EXC_EN
                    nxt = S_EXC;
`else
                    nxt = S_IF;
`endif
                end
                else               nxt = S_EX;
            end
            S_EX: begin
                if (d_branch)          nxt = S_IF;
                else if (d_lw || d_sw) nxt = S_MEM;
                else                   nxt = S_WB;
            end
            S_MEM: begin
                if (timeout)      nxt = S_HALT;
                else if (mem_rdy) nxt = d_lw ? S_WB : S_IF;
            end
            S_WB:    nxt = S_IF;
            S_EXC:   nxt = S_IF;
            S_HALT:  nxt = S_HALT;
            default: nxt = S_IF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur      <= S_IF;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
            instret  <= '0;
        end else begin
            cur <= nxt;
            if (nxt != cur)
                wait_cnt <= '0;
            else if (waiting)
                wait_cnt <= wait_cnt + CNT_W'(1);
            if (timeout)
                mem_err <= 1'b1;
            if (retire)
                instret <= instret + INSTRET_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl with random instruction stream
module tb_multicycle_ctrl;

    localparam int TMO = 4;
    localparam int IW  = 4;

    localparam int K_JMP = 0, K_ILL = 1, K_BR = 2, K_JAL = 3, K_ALU = 4, K_SW = 5, K_LW = 6;

`ifdef MULTICYCLE_CTRL_EXC_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [5:0]    Op = '0;
    logic [5:0]    Func = '0;
    logic          mem_rdy = 1'b0;
    logic          mem_req, MemW, IRWr, PCWr, RegW;
    logic [2:0]    NPCOp;
    logic [1:0]    RegDst, MemToReg;
    logic          ALUSrc1, ALUSrc2;
    logic [4:0]    ALUOp;
    logic [1:0]    EXTOp;
    logic [2:0]    state;
    logic          mem_err;
    logic [IW-1:0] instret;
`ifdef MULTICYCLE_CTRL_EXC_EN
    logic          exc;
`endif

    multicycle_ctrl #(.MEM_TIMEOUT(TMO), .INSTRET_W(IW)) dut (
        .clk(clk), .rst(rst), .Op(Op), .Func(Func), .mem_rdy(mem_rdy),
        .mem_req(mem_req), .MemW(MemW), .IRWr(IRWr), .PCWr(PCWr), .RegW(RegW),
        .NPCOp(NPCOp), .RegDst(RegDst), .MemToReg(MemToReg),
        .ALUSrc1(ALUSrc1), .ALUSrc2(ALUSrc2), .ALUOp(ALUOp), .EXTOp(EXTOp),
        .state(state), .mem_err(mem_err), .instret(instret)
`ifdef MULTICYCLE_CTRL_EXC_EN
        , .exc(exc)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] op;
        logic [5:0] func;
        bit         any_func;
        int         kind;
        logic [2:0] npc;
        logic [12:0] dec;   // {RegDst, MemToReg, ALUSrc1, ALUSrc2, ALUOp, EXTOp}
    } ent_t;

    typedef struct {
        logic [12:0]   dec;
        logic [2:0]    npc;
        int            lat;
        logic [2:0]    st;
        logic          regw;
        logic [IW-1:0] inst;
        int            nreq;
        int            nmw;
        logic          excx;
    } exp_t;

    ent_t          tab[$];
    exp_t          exp_q[$];
    bit            mon_en = 1'b0;
    logic [IW-1:0] model_cnt;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    function automatic void add(input logic [5:0] op, input logic [5:0] func, input bit anyf,
                                input int kind, input logic [2:0] npc, input logic [1:0] rdst,
                                input logic [1:0] m2r, input logic s1, input logic s2,
                                input logic [4:0] alu, input logic [1:0] ext);
        ent_t e;
        e.op = op; e.func = func; e.any_func = anyf; e.kind = kind; e.npc = npc;
        e.dec = {rdst, m2r, s1, s2, alu, ext};
        tab.push_back(e);
    endfunction

    function automatic logic [31:0] strobes();
        return 32'({mem_req, MemW, IRWr, PCWr, RegW});
    endfunction

    function automatic logic [31:0] decode_now();
        return 32'({NPCOp, RegDst, MemToReg, ALUSrc1, ALUSrc2, ALUOp, EXTOp});
    endfunction

    // Monitor: per-instruction activity is accumulated and checked when PCWr retires it.
    int   m_cyc, m_req, m_ir, m_mw, m_rw;
    exp_t m_e;
    always @(negedge clk) begin
        if (!mon_en) begin
            m_cyc = 0; m_req = 0; m_ir = 0; m_mw = 0; m_rw = 0;
        end else begin
            m_cyc++;
            m_req += int'(mem_req);
            m_ir  += int'(IRWr);
            m_mw  += int'(MemW);
            m_rw  += int'(RegW);
            if (exp_q.size() != 0)
                chk("decode_hold", 32'({RegDst, MemToReg, ALUSrc1, ALUSrc2, ALUOp, EXTOp}),
                    32'(exp_q[0].dec));
            if (PCWr) begin
                if (exp_q.size() == 0) begin
                    chk("retire_with_empty_queue", 32'(exp_q.size()), 32'd1);
                end else begin
                    m_e = exp_q.pop_front();
                    chk("latency", 32'(m_cyc), 32'(m_e.lat));
                    chk("retire_state", 32'(state), 32'(m_e.st));
                    chk("retire_npcop", 32'(NPCOp), 32'(m_e.npc));
                    chk("retire_regw", 32'(RegW), 32'(m_e.regw));
                    chk("instret", 32'(instret), 32'(m_e.inst));
                    chk("mem_req_cycles", 32'(m_req), 32'(m_e.nreq));
                    chk("irwr_cycles", 32'(m_ir), 32'd1);
                    chk("memw_cycles", 32'(m_mw), 32'(m_e.nmw));
                    chk("regw_cycles", 32'(m_rw), 32'(m_e.regw));
                    chk("mem_err_clear", 32'(mem_err), 32'd0);
`ifdef MULTICYCLE_CTRL_EXC_EN
                    chk("exc", 32'(exc), 32'(m_e.excx));
`endif
                end
                m_cyc = 0; m_req = 0; m_ir = 0; m_mw = 0; m_rw = 0;
            end
        end
    end

    task automatic run_instr();
        ent_t e;
        exp_t x;
        int   s1, s2;
        bit   rq[$];
        bit   is_exc;
        e  = tab[$urandom_range(0, tab.size() - 1)];
        Op = e.op;
        Func = e.any_func ? 6'($urandom) : e.func;
        s1 = $urandom_range(0, 3);
        s2 = $urandom_range(0, 3);
        is_exc = (e.kind == K_ILL) && EXC_EN;
        repeat (s1) rq.push_back(1'b0);
        rq.push_back(1'b1);
        rq.push_back(1'($urandom));
        case (e.kind)
            K_ILL: if (is_exc) rq.push_back(1'($urandom));
            K_BR, K_JAL: rq.push_back(1'($urandom));
            K_ALU: begin rq.push_back(1'($urandom)); rq.push_back(1'($urandom)); end
            K_SW, K_LW: begin
                rq.push_back(1'($urandom));
                repeat (s2) rq.push_back(1'b0);
                rq.push_back(1'b1);
                if (e.kind == K_LW) rq.push_back(1'($urandom));
            end
            default: ;
        endcase
        x.dec  = e.dec;
        x.npc  = is_exc ? 3'b101 : e.npc;
        x.lat  = rq.size();
        case (e.kind)
            K_JMP:        x.st = 3'd1;
            K_ILL:        x.st = is_exc ? 3'd5 : 3'd1;
            K_BR:         x.st = 3'd2;
            K_SW:         x.st = 3'd3;
            default:      x.st = 3'd4;
        endcase
        x.regw = (e.kind == K_ALU) || (e.kind == K_LW) || (e.kind == K_JAL);
        x.inst = model_cnt;
        x.nreq = s1 + 1 + (((e.kind == K_SW) || (e.kind == K_LW)) ? s2 + 1 : 0);
        x.nmw  = (e.kind == K_SW) ? s2 + 1 : 0;
        x.excx = is_exc;
        if (!is_exc) model_cnt = model_cnt + 1'b1;
        exp_q.push_back(x);
        foreach (rq[i]) begin
            mem_rdy = rq[i];
            @(posedge clk); #1;
        end
    endtask

    initial begin
        //    op     func   any   kind   npc  rdst m2r  s1 s2 alu ext
        add(6'h00, 6'h21, 1'b0, K_ALU, 3'd0, 2'd1, 2'd0, 0, 0, 5'd1,  2'd0);
        add(6'h00, 6'h20, 1'b0, K_ALU, 3'd0, 2'd1, 2'd0, 0, 0, 5'd2,  2'd0);
        add(6'h00, 6'h23, 1'b0, K_ALU, 3'd0, 2'd1, 2'd0, 0, 0, 5'd3,  2'd0);
        add(6'h00, 6'h22, 1'b0, K_ALU, 3'd0, 2'd1, 2'd0, 0, 0, 5'd4,  2'd0);
        add(6'h00, 6'h2A, 1'b0, K_ALU, 3'd0, 2'd1, 2'd0, 0, 0, 5'd9,  2'd0);
        add(6'h00, 6'h00, 1'b0, K_ALU, 3'd0, 2'd1, 2'd0, 0, 1, 5'd17, 2'd0);
        add(6'h00, 6'h02, 1'b0, K_ALU, 3'd0, 2'd1, 2'd0, 0, 1, 5'd18, 2'd0);
        add(6'h00, 6'h03, 1'b0, K_ALU, 3'd0, 2'd1, 2'd0, 0, 1, 5'd19, 2'd0);
        add(6'h00, 6'h08, 1'b0, K_JMP, 3'd4, 2'd1, 2'd0, 0, 0, 5'd25, 2'd0);
        add(6'h23, 6'h00, 1'b1, K_LW,  3'd0, 2'd0, 2'd1, 1, 0, 5'd2,  2'd1);
        add(6'h2B, 6'h00, 1'b1, K_SW,  3'd0, 2'd0, 2'd0, 1, 0, 5'd2,  2'd1);
        add(6'h04, 6'h00, 1'b1, K_BR,  3'd1, 2'd0, 2'd0, 0, 0, 5'd11, 2'd1);
        add(6'h05, 6'h00, 1'b1, K_BR,  3'd3, 2'd0, 2'd0, 0, 0, 5'd12, 2'd0);
        add(6'h02, 6'h00, 1'b1, K_JMP, 3'd2, 2'd0, 2'd0, 0, 0, 5'd23, 2'd0);
        add(6'h03, 6'h00, 1'b1, K_JAL, 3'd2, 2'd2, 2'd2, 0, 0, 5'd24, 2'd0);
        add(6'h0D, 6'h00, 1'b1, K_ALU, 3'd0, 2'd0, 2'd0, 1, 0, 5'd21, 2'd0);
        add(6'h0F, 6'h00, 1'b1, K_ALU, 3'd0, 2'd0, 2'd0, 1, 0, 5'd22, 2'd2);
        add(6'h0A, 6'h00, 1'b1, K_ALU, 3'd0, 2'd0, 2'd0, 1, 0, 5'd20, 2'd1);
        add(6'h08, 6'h00, 1'b1, K_ALU, 3'd0, 2'd0, 2'd0, 1, 0, 5'd26, 2'd1);
        add(6'h3F, 6'h00, 1'b1, K_ILL, 3'd0, 2'd0, 2'd0, 0, 0, 5'd0,  2'd0);
        add(6'h00, 6'h3F, 1'b0, K_ILL, 3'd0, 2'd0, 2'd0, 0, 0, 5'd0,  2'd0);
        add(6'h01, 6'h00, 1'b1, K_ILL, 3'd0, 2'd0, 2'd0, 0, 0, 5'd0,  2'd0);

        // Reset holds everything quiet even with a lw presented and memory ready.
        rst = 1'b1; Op = 6'h23; Func = 6'h00; mem_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("reset_state", 32'(state), 32'd0);
            chk("reset_strobes", strobes(), 32'd0);
            chk("reset_decode", decode_now(), 32'd0);
            chk("reset_mem_err", 32'(mem_err), 32'd0);
            chk("reset_instret", 32'(instret), 32'd0);
        end

        model_cnt = '0;
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (300) run_instr();
        mon_en = 1'b0;
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("instret_final", 32'(instret), 32'(model_cnt));

        // Reset asserted in EX abandons the addu.
        Op = 6'h00; Func = 6'h21; mem_rdy = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_ex_state", 32'(state), 32'd2);
        rst = 1'b1; #1;
        chk("mid_rst_strobes", strobes(), 32'd0);
        @(posedge clk); #1;
        chk("mid_rst_state", 32'(state), 32'd0);
        chk("mid_rst_instret", 32'(instret), 32'd0);
        rst = 1'b0; mem_rdy = 1'b0; #1;
        chk("mid_after_strobes", strobes(), 32'h10);
        @(posedge clk); #1;
        chk("mid_after_state", 32'(state), 32'd0);

        // Fetch timeout: four unanswered cycles end in HALT.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; mem_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("tmo_wait_state", 32'(state), 32'd0);
            chk("tmo_wait_err", 32'(mem_err), 32'd0);
        end
        @(posedge clk); #1;
        chk("tmo_state", 32'(state), 32'd6);
        chk("tmo_err", 32'(mem_err), 32'd1);
        for (int i = 0; i < 5; i++) begin
            Op = 6'($urandom); Func = 6'($urandom); mem_rdy = 1'($urandom); #1;
            chk("halt_strobes", strobes(), 32'd0);
            chk("halt_decode", decode_now(), 32'd0);
            @(posedge clk); #1;
            chk("halt_state", 32'(state), 32'd6);
            chk("halt_err", 32'(mem_err), 32'd1);
        end

        // mem_rdy on the limit cycle wins; then a lw times out in MEM.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; mem_rdy = 1'b0; Op = 6'h23; Func = 6'h00;
        repeat (3) begin @(posedge clk); #1; end
        mem_rdy = 1'b1; #1;
        chk("edge_irwr", 32'(IRWr), 32'd1);
        @(posedge clk); #1;
        chk("edge_state", 32'(state), 32'd1);
        chk("edge_err", 32'(mem_err), 32'd0);
        mem_rdy = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mem_enter_state", 32'(state), 32'd3);
        chk("mem_lw_memw", 32'(MemW), 32'd0);
        repeat (3) begin @(posedge clk); #1; end
        chk("mem_wait_state", 32'(state), 32'd3);
        chk("mem_wait_err", 32'(mem_err), 32'd0);
        @(posedge clk); #1;
        chk("mem_tmo_state", 32'(state), 32'd6);
        chk("mem_tmo_err", 32'(mem_err), 32'd1);
        chk("mem_tmo_instret", 32'(instret), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Next-generation MIPS control unit for the multi-cycle datapath.
- Decodes Op/Func from the instruction register and sequences each instruction through fetch, decode, execute, memory and writeback states.
- Handshakes with a variable-latency unified memory, with a parametrised timeout.
- Keeps a retired-instruction counter.

Parameters:
MEM_TIMEOUT, 16, max cycles to wait for mem_rdy per access; 0 disables the timeout
INSTRET_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
Op  in  6  IR[31:26]
Func  in  6  IR[5:0]
mem_rdy  in  1  memory completes the current request this cycle
mem_req  out  1  memory request (fetch or data)
MemW  out  1  write qualifier for mem_req (sw data phase only)
IRWr  out  1  load IR from memory read data
PCWr  out  1  update PC with NPC output
RegW  out  1  register-file write strobe
NPCOp  out  3  000 PC+4, 001 beq, 010 j/jal, 011 bne, 100 jr
RegDst  out  2  00 rt, 01 rd (R-type), 10 $31 (jal)
MemToReg  out  2  00 ALU, 01 memory (lw), 10 PC+4 (jal)
ALUSrc1  out  1  B operand = extended immediate (lw, sw, ori, lui, slti, addi)
ALUSrc2  out  1  A operand = shamt (sll, srl, sra)
ALUOp  out  5  ALU function code
EXTOp  out  2  00 zero-ext, 01 sign-ext (addi, lw, sw, beq, slti), 10 lui
state  out  3  current FSM state, for debug
mem_err  out  1  sticky memory timeout flag
instret  out  INSTRET_W  retired-instruction count

Behaviour:
- States: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=6.
- Only the state register, the wait counter, mem_err and instret are registered.
- All other outputs are combinational from state, Op, Func and mem_rdy.
- Reset, while rst=1: every strobe (mem_req, MemW, IRWr, PCWr, RegW) is 0, all decode outputs are 0, state<=IF, wait counter<=0, mem_err<=0, instret<=0.
- Decode outputs (NPCOp, RegDst, MemToReg, ALUSrc1/2, ALUOp, EXTOp) are pure decode of Op/Func and are held in every non-HALT state.
- ALUOp codes: addu 1, add/lw/sw 2, subu 3, sub 4, slt 9, beq 11, bne 12, sll 17, srl 18, sra 19, slti 20, ori 21, lui 22, j 23, jal 24, jr 25, addi 26.
- IF:
  - mem_req=1.
  - mem_rdy=1: IRWr=1, go to ID.
  - Otherwise stay in IF.
- ID:
  - j or jr: PCWr=1, go to IF.
  - jal: go to WB.
  - Unsupported opcode or Func: PCWr=1 with NPCOp=000 (executes as a nop), go to IF.
  - Otherwise go to EX.
- EX:
  - beq or bne: PCWr=1, go to IF. The taken/not-taken decision (Zero) is made inside NPC.
  - lw or sw: go to MEM.
  - Otherwise go to WB.
- MEM:
  - mem_req=1; MemW=1 for sw.
  - On mem_rdy, lw: go to WB.
  - On mem_rdy, sw: PCWr=1, go to IF.
- WB:
  - RegW=1 and PCWr=1, go to IF.
  - Writing instructions: R-type except jr, lw, ori, addi, lui, slti, jal.
- Instruction latency with mem_rdy tied high:
  - j/jr/nop: 2 cycles.
  - beq/bne: 3 cycles.
  - jal: 3 cycles.
  - R-type/immediate ALU ops: 4 cycles.
  - sw: 4 cycles.
  - lw: 5 cycles.
- Wait counter:
  - Clears on every state change.
  - Increments each cycle in IF or MEM while mem_rdy=0.
  - Timeout when MEM_TIMEOUT!=0 and the counter reaches MEM_TIMEOUT-1 with mem_rdy still 0: mem_err<=1, go to HALT.
  - mem_rdy in the same cycle as the timeout limit wins: no error.
- HALT: all strobes 0; held until rst.
- instret:
  - Increments by 1 in every cycle where PCWr=1.
  - Wraps modulo 2^INSTRET_W.
- Reset mid-instruction: abandons it immediately; the next cycle after rst falls is IF with no strobes carried over.

Optional Feature:
- Macro: MULTICYCLE_CTRL_EXC_EN.
- With the macro defined:
  - Adds output exc (1 bit) and state EXC=5.
  - An unsupported Op/Func in ID goes to EXC instead of executing as a nop.
  - EXC lasts one cycle: exc=1, PCWr=1, NPCOp=101 (handler vector), RegW=0, MemW=0; then go to IF.
  - instret does not count exception cycles.
- Without the macro: no exc port, no EXC state, illegal instructions execute as a nop.

Test Plan:
1. rst=1 for 3 cycles, then released; mem_rdy=1; fetch addu (Op=0, Func=0x21) -> states 0,1,2,4,0; RegDst=01, ALUOp=1, RegW=1 in WB only; instret=1.
2. lw (Op=0x23), mem_rdy low 3 cycles in MEM -> MEM held 4 cycles, MemW=0, then WB with MemToReg=01, EXTOp=01, ALUOp=2; mem_err=0.
3. sw (Op=0x2B) -> MEM with mem_req=1 and MemW=1; on mem_rdy, PCWr=1 and next state IF; RegW never 1.
4. Timeout: MEM_TIMEOUT=4, mem_rdy held 0 in IF -> mem_err=1 after 4 cycles, state=6, strobes 0 until rst; a second bench with mem_rdy=1 on cycle 4 -> no error.
5. Control flow: jal (Op=0x03) -> ID,WB with RegDst=10, MemToReg=10, NPCOp=010; jr (Func=0x08) -> PCWr in ID with NPCOp=100, 2 cycles; bne (Op=0x05) -> NPCOp=011 in EX.
6. Illegal Op=0x3F: without the macro, nop with PCWr in ID; with MULTICYCLE_CTRL_EXC_EN, exc=1 and NPCOp=101 for one cycle, instret unchanged. Also assert rst in EX mid-instruction -> IF next cycle, instret=0.
